// File: rtl/dpsf_arb_ctrl_if.sv
// rtl/dpsf_arb_ctrl_if.sv - producer, FIFO and consumer signal bundle for dpsf_arb_ctrl
interface dpsf_arb_ctrl_if #(
    parameter int pWidth = 16,
    parameter int pAddr  = 4
);
    logic              ReqA;
    logic [pWidth-1:0] DIA;
    logic              AckA;
    logic              ReqB;
    logic [pWidth-1:0] DIB;
    logic              AckB;
    logic              WE;
    logic [pWidth-1:0] DI;
    logic              RE;
    logic [pWidth-1:0] DO;
    logic              EF;
    logic              FF;
    logic [pAddr:0]    Cnt;
    logic              OVld;
    logic [pWidth-1:0] OD;
    logic              ORdy;
    logic              Err;

    modport master (
        input  ReqA, DIA, ReqB, DIB, DO, EF, FF, Cnt, ORdy,
        output AckA, AckB, WE, DI, RE, OVld, OD, Err
    );

    modport slave (
        output ReqA, DIA, ReqB, DIB, DO, EF, FF, Cnt, ORdy,
        input  AckA, AckB, WE, DI, RE, OVld, OD, Err
    );
endinterface

// File: rtl/dpsf_arb_ctrl.sv
// rtl/dpsf_arb_ctrl.sv - round-robin two-producer FIFO writer and single-entry output drain
module dpsf_arb_ctrl #(
    parameter int pWidth = 16,
    parameter int pAddr  = 4
) (
    input  logic            Clk,
    input  logic            Rst,
    dpsf_arb_ctrl_if.master bus
);
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_t;

    localparam logic [pAddr:0] DEPTH = {1'b1, {pAddr{1'b0}}};

    last_t             last_q, last_d;
    logic              we_q, ack_a_q, ack_b_q, ovld_q, err_q;
    logic [pWidth-1:0] di_q, od_q;
    logic              space_ok, elig_a, elig_b, grant_a, grant_b, re;

    // The in-flight registered write is not yet in Cnt, so count it here.
    assign space_ok = (bus.Cnt + {{pAddr{1'b0}}, we_q}) < DEPTH;
    assign elig_a   = bus.ReqA & ~ack_a_q;
    assign elig_b   = bus.ReqB & ~ack_b_q;
    assign re       = ~Rst & ~bus.EF & (~ovld_q | bus.ORdy);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            last_q <= LAST_B;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        last_d  = last_q;
        if (space_ok) begin
            if (elig_a && (!elig_b || last_q == LAST_B)) begin
                grant_a = 1'b1;
            end else if (elig_b) begin
                grant_b = 1'b1;
            end
        end
        if (grant_a) begin
            last_d = LAST_A;
        end else if (grant_b) begin
            last_d = LAST_B;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            we_q    <= 1'b0;
            di_q    <= '0;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
        end else begin
            we_q    <= grant_a | grant_b;
            ack_a_q <= grant_a;
            ack_b_q <= grant_b;
            if (grant_a) begin
                di_q <= bus.DIA;
            end else if (grant_b) begin
                di_q <= bus.DIB;
            end
        end
    end

    // A refill on the consume edge keeps OVld high for one word per clock.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ovld_q <= 1'b0;
            od_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            if (re) begin
                od_q   <= bus.DO;
                ovld_q <= 1'b1;
            end else if (ovld_q && bus.ORdy) begin
                ovld_q <= 1'b0;
            end
            if ((we_q && bus.FF) || (re && bus.EF)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.WE   = we_q;
    assign bus.DI   = di_q;
    assign bus.AckA = ack_a_q;
    assign bus.AckB = ack_b_q;
    assign bus.RE   = re;
    assign bus.OVld = ovld_q;
    assign bus.OD   = od_q;
    assign bus.Err  = err_q;
endmodule
